// File: rtl/button_event.sv
// Turns a debounced button level into registered single-cycle press, release,
// tap, long-press and auto-repeat pulses, plus a held level.
module button_event #(
    parameter int LONG_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000,
    parameter int CNT_W         = 26
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
    input  logic rpt_en,
    output logic press,
    output logic release_evt,
    output logic tap,
    output logic long_press,
    output logic repeat_evt,
    output logic held
);

    localparam logic [1:0] WAIT_LOW = 2'd0;
    localparam logic [1:0] IDLE     = 2'd1;
    localparam logic [1:0] HELD     = 2'd2;
    localparam logic [1:0] LONG     = 2'd3;

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ZERO    = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    logic [1:0]       state_r;
    logic [1:0]       state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [CNT_W-1:0] cnt_inc_s;
    logic             press_r, release_r, tap_r, long_r, repeat_r, held_r;
    logic             press_nxt_s, release_nxt_s, tap_nxt_s;
    logic             long_nxt_s, repeat_nxt_s, held_nxt_s;

    assign cnt_inc_s = cnt_r + CNT_ONE;

    // Next-state, counter and pulse decode; a low sample always wins over thresholds.
    always_comb begin
        state_nxt_s   = state_r;
        cnt_nxt_s     = cnt_r;
        press_nxt_s   = 1'b0;
        release_nxt_s = 1'b0;
        tap_nxt_s     = 1'b0;
        long_nxt_s    = 1'b0;
        repeat_nxt_s  = 1'b0;
        case (state_r)
            WAIT_LOW: begin
                if (!in) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = WAIT_LOW;
                end
            end
            IDLE: begin
                if (in) begin
                    state_nxt_s = HELD;
                    cnt_nxt_s   = CNT_ONE;
                    press_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            HELD: begin
                if (!in) begin
                    state_nxt_s   = IDLE;
                    cnt_nxt_s     = CNT_ZERO;
                    release_nxt_s = 1'b1;
                    tap_nxt_s     = 1'b1;
                end else if (cnt_inc_s == LONG_LAST) begin
                    state_nxt_s = LONG;
                    cnt_nxt_s   = CNT_ZERO;
                    long_nxt_s  = 1'b1;
                end else begin
                    cnt_nxt_s = cnt_inc_s;
                end
            end
            LONG: begin
                // The counter free-runs even with rpt_en low so cadence stays
                // locked to the long-press instant.
                if (!in) begin
                    state_nxt_s   = IDLE;
                    cnt_nxt_s     = CNT_ZERO;
                    release_nxt_s = 1'b1;
                end else if (cnt_inc_s == REPEAT_LAST) begin
                    cnt_nxt_s    = CNT_ZERO;
                    repeat_nxt_s = rpt_en;
                end else begin
                    cnt_nxt_s = cnt_inc_s;
                end
            end
            default: begin
                state_nxt_s = WAIT_LOW;
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase
        held_nxt_s = (state_nxt_s == HELD) || (state_nxt_s == LONG);
    end

    // State, counter and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= WAIT_LOW;
            cnt_r     <= CNT_ZERO;
            press_r   <= 1'b0;
            release_r <= 1'b0;
            tap_r     <= 1'b0;
            long_r    <= 1'b0;
            repeat_r  <= 1'b0;
            held_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            press_r   <= press_nxt_s;
            release_r <= release_nxt_s;
            tap_r     <= tap_nxt_s;
            long_r    <= long_nxt_s;
            repeat_r  <= repeat_nxt_s;
            held_r    <= held_nxt_s;
        end
    end

    assign press       = press_r;
    assign release_evt = release_r;
    assign tap         = tap_r;
    assign long_press  = long_r;
    assign repeat_evt  = repeat_r;
    assign held        = held_r;

endmodule

// File: tb/tb_button_event.sv
// Directed-vector bench for button_event with LONG_CYCLES=8, REPEAT_CYCLES=3.
module tb_button_event;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in = 1'b0;
    logic rpt_en = 1'b0;
    logic press, release_evt, tap, long_press, repeat_evt, held;

    int chk_cnt = 0;
    int pass_cnt = 0;

    // Output vector {press, release, tap, long_press, repeat, held}
    localparam logic [5:0] N = 6'b000000;
    localparam logic [5:0] P = 6'b100000;
    localparam logic [5:0] R = 6'b010000;
    localparam logic [5:0] T = 6'b001000;
    localparam logic [5:0] L = 6'b000100;
    localparam logic [5:0] Q = 6'b000010;
    localparam logic [5:0] H = 6'b000001;

    button_event #(.LONG_CYCLES(8), .REPEAT_CYCLES(3), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .in(in), .rpt_en(rpt_en),
        .press(press), .release_evt(release_evt), .tap(tap),
        .long_press(long_press), .repeat_evt(repeat_evt), .held(held)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        chk_cnt++;
        if (obs === exp) pass_cnt++;
        else $display("FAIL %s: got %b expected %b", tag, obs, exp);
    endtask

    // Apply inputs for one edge, then sample the registered outputs just after it.
    task automatic cyc(input logic rst_v, input logic in_v, input logic rpt_v,
                       input logic [5:0] exp, input string tag);
        rst = rst_v;
        in = in_v;
        rpt_en = rpt_v;
        @(posedge clk);
        #1;
        check(tag, {press, release_evt, tap, long_press, repeat_evt, held}, exp);
    endtask

    task automatic hold_n(input int n, input logic rpt_v, input string tag);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, rpt_v, H, tag);
    endtask

    initial begin
        #1;
        cyc(1'b1, 1'b0, 1'b0, N, "reset");
        cyc(1'b0, 1'b0, 1'b0, N, "wait_low_exit");

        // Tap: 5 high edges
        cyc(1'b0, 1'b1, 1'b0, P | H, "tap_press");
        hold_n(4, 1'b0, "tap_held");
        cyc(1'b0, 1'b0, 1'b0, R | T, "tap_release");
        cyc(1'b0, 1'b0, 1'b0, N, "tap_idle");

        // Long with repeat: 15 high edges, rpt_en=1
        cyc(1'b0, 1'b1, 1'b1, P | H, "lr_press");
        hold_n(6, 1'b1, "lr_held");
        cyc(1'b0, 1'b1, 1'b1, L | H, "lr_long");
        hold_n(2, 1'b1, "lr_held2");
        cyc(1'b0, 1'b1, 1'b1, Q | H, "lr_rep11");
        hold_n(2, 1'b1, "lr_held3");
        cyc(1'b0, 1'b1, 1'b1, Q | H, "lr_rep14");
        cyc(1'b0, 1'b1, 1'b1, H, "lr_e15");
        cyc(1'b0, 1'b0, 1'b1, R, "lr_release");

        // Threshold: 7 high edges gives a tap
        cyc(1'b0, 1'b1, 1'b0, P | H, "th7_press");
        hold_n(6, 1'b0, "th7_held");
        cyc(1'b0, 1'b0, 1'b0, R | T, "th7_release");

        // Threshold: exactly 8 high edges gives long then plain release
        cyc(1'b0, 1'b1, 1'b1, P | H, "th8_press");
        hold_n(6, 1'b1, "th8_held");
        cyc(1'b0, 1'b1, 1'b1, L | H, "th8_long");
        cyc(1'b0, 1'b0, 1'b1, R, "th8_release");

        // Repeat gating: rpt_en low over edges 9..11
        cyc(1'b0, 1'b1, 1'b1, P | H, "rg_press");
        hold_n(6, 1'b1, "rg_held");
        cyc(1'b0, 1'b1, 1'b1, L | H, "rg_long");
        hold_n(3, 1'b0, "rg_gated");
        hold_n(2, 1'b1, "rg_held2");
        cyc(1'b0, 1'b1, 1'b1, Q | H, "rg_rep14");
        cyc(1'b0, 1'b0, 1'b1, R, "rg_release");

        // Reset while held, then button must go low before a new press
        cyc(1'b0, 1'b1, 1'b0, P | H, "rh_press");
        hold_n(3, 1'b0, "rh_held");
        cyc(1'b1, 1'b1, 1'b0, N, "rh_reset");
        cyc(1'b0, 1'b1, 1'b0, N, "rh_stuck1");
        cyc(1'b0, 1'b1, 1'b0, N, "rh_stuck2");
        cyc(1'b0, 1'b0, 1'b0, N, "rh_low");
        cyc(1'b0, 1'b1, 1'b0, P | H, "rh_repress");
        cyc(1'b0, 1'b0, 1'b0, R | T, "rh_release");

        // Back-to-back: 1,0,1 then 0
        cyc(1'b0, 1'b1, 1'b0, P | H, "bb_press1");
        cyc(1'b0, 1'b0, 1'b0, R | T, "bb_release1");
        cyc(1'b0, 1'b1, 1'b0, P | H, "bb_press2");
        cyc(1'b0, 1'b0, 1'b0, R | T, "bb_release2");
        cyc(1'b0, 1'b0, 1'b0, N, "bb_idle");

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/button_event.md
# button_event

Converts the clean, debounced level from a push-button debouncer into registered single-cycle event pulses: press, release, tap (short press), long press and auto-repeat. It sits directly downstream of the debouncer and feeds the control FSMs, which then never see raw levels or have to time button holds themselves. One instance is used per button.

## Interface
Parameters:
- LONG_CYCLES, 50_000_000: consecutive high samples of `in` that qualify a long press; must be ≥2 and < 2^CNT_W.
- REPEAT_CYCLES, 10_000_000: high samples between auto-repeat pulses after a long press; must be ≥1 and < 2^CNT_W.
- CNT_W, 26: width of the hold counter.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in  in  1  debounced button level, already synchronous to clk; 1 = pressed.
- rpt_en  in  1  auto-repeat enable, sampled every edge.
- press  out  1  one-cycle pulse at the start of a press.
- release  out  1  one-cycle pulse at the end of any press.
- tap  out  1  one-cycle pulse, coincident with `release`, only for presses shorter than LONG_CYCLES.
- long_press  out  1  one-cycle pulse when a hold reaches LONG_CYCLES.
- repeat  out  1  one-cycle pulse every REPEAT_CYCLES once a hold is long, while rpt_en=1.
- held  out  1  level; high while a press is in progress (states HELD and LONG).

## Operation
- FSM states: WAIT_LOW, IDLE, HELD, LONG. The hold counter `cnt` is CNT_W bits wide.
- Reset (rst=1 sampled at an edge): state goes to WAIT_LOW, cnt to 0, and all outputs to 0. Reset overrides every other transition.
- WAIT_LOW: if in=0, go to IDLE. The block needs `in` low at least once after reset, so a button held through reset never produces a press.
- IDLE: if in=1, go to HELD, set cnt=1 and pulse press.
- HELD with in=1:
  - if cnt+1 == LONG_CYCLES, go to LONG, set cnt=0 and pulse long_press;
  - otherwise increment cnt.
- HELD with in=0: go to IDLE, set cnt=0, pulse release and tap.
- LONG with in=1:
  - if cnt+1 == REPEAT_CYCLES, set cnt=0 and pulse repeat only when rpt_en=1;
  - otherwise increment cnt.
  - The counter keeps running while rpt_en=0, so repeat cadence stays aligned to the long_press instant.
- LONG with in=0: go to IDLE, set cnt=0, pulse release; no tap.
- Counter bounds: cnt never exceeds max(LONG_CYCLES, REPEAT_CYCLES)−1. No wrap or saturation logic is needed.
- Simultaneous events: a low sample always takes priority. An edge with in=0 is never counted toward the long or repeat thresholds.
- At most one of press, long_press, repeat, release is high in any cycle. tap is only ever high together with release.

## Timing
- Number the edges at which `in` is sampled high from 1 at the first high sample in IDLE. All outputs are registered, so each pulse is high for the single cycle after the deciding edge.
- press: after high edge 1. Latency from `in` rising is one clock.
- long_press: after high edge LONG_CYCLES.
- repeat: after high edge LONG_CYCLES + k·REPEAT_CYCLES, for k ≥ 1.
- release (and tap, when applicable): after the first edge at which in=0.
- held: rises together with press and falls together with release.
- Minimum press: a single high sample gives press in one cycle, then release and tap in the next cycle.
- Back-to-back presses: a press can be recognised at the edge immediately after the release edge (IDLE needs no dwell cycle).
- Reset mid-hold: outputs drop to 0 in the cycle after the reset edge. No release pulse is issued for the aborted press.

## Test plan
Use LONG_CYCLES=8 and REPEAT_CYCLES=3 unless noted.
- Tap: release from reset with in=0, then in=1 for 5 edges, then 0 -> press after edge 1; held high for 5 cycles; release and tap after edge 6; long_press never asserted.
- Long with repeat: rpt_en=1, in=1 for 15 edges, then 0 -> press after edge 1; long_press after edge 8; repeat after edges 11 and 14; release after edge 16 with tap=0.
- Threshold boundary: 7 high edges -> tap, no long_press. Exactly 8 high edges -> long_press then release, no tap, no repeat.
- Repeat gating: as in "Long with repeat" but rpt_en=0 from edge 9 to 11, then 1 -> no repeat after edge 11; repeat after edge 14.
- Reset while held: hold in=1 and pulse rst=1 for one edge after edge 4 -> all outputs 0, no release. press does not reappear while in stays 1. in=0 for one edge, then in=1 -> press.
- Back-to-back: in pattern 1,0,1 over three edges -> press, then release with tap, then press on consecutive cycles.
